// File: rtl/ctrl_pipeline_stages_pkg.sv
// Shared control-word bit map and write-destination encodings for the control
// unit and the pipeline-register block.
package ctrl_pkg;

  localparam int CW_W = 24;

  localparam int B_LOAD       = 0;
  localparam int B_MEMTOREG   = 1;
  localparam int B_LOEN       = 2;
  localparam int B_RFEN       = 3;
  localparam int B_HIEN       = 4;
  localparam int B_MEM_MUX    = 5;
  localparam int B_DM_SE      = 6;
  localparam int F_DM_SIZE_LO = 7;
  localparam int F_DM_SIZE_HI = 8;
  localparam int B_DM_EN      = 9;
  localparam int B_DM_RW      = 10;
  localparam int F_ALUOP_LO   = 11;
  localparam int F_ALUOP_HI   = 13;
  localparam int F_S0S2_LO    = 14;
  localparam int F_S0S2_HI    = 15;
  localparam int B_RS_MUX     = 16;
  localparam int B_BASE_MUX   = 17;
  localparam int F_WD_LO      = 18;
  localparam int F_WD_HI      = 19;
  localparam int B_CMUX       = 20;
  localparam int B_JAL_ADDER  = 21;
  localparam int B_JUMP       = 22;
  localparam int B_COND_MUX   = 23;

  typedef enum logic [1:0] {
    WD_NONE = 2'b00,
    WD_RT   = 2'b01,
    WD_R31  = 2'b10,
    WD_RD   = 2'b11
  } wd_e;

  function automatic logic [4:0] resolve_dest(input logic [1:0] wd,
                                              input logic [4:0] rt,
                                              input logic [4:0] rd);
    case (wd_e'(wd))
      WD_RT:   return rt;
      WD_R31:  return 5'd31;
      WD_RD:   return rd;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_pipeline_stages_if.sv
// ID-stage inputs and per-stage control slices of the pipeline-register block.
interface ctrl_pipeline_stages_if #(
  parameter int CW_W  = ctrl_pkg::CW_W,
  parameter int CNT_W = 16
);
  logic [CW_W-1:0]  ctrl_id;
  logic [4:0]       rs_id;
  logic [4:0]       rt_id;
  logic [4:0]       rd_id;
  logic             flush;
  logic             hazard_stall;
  logic [6:0]       ex_ctrl;
  logic [4:0]       ex_dest;
  logic [5:0]       mem_ctrl;
  logic [4:0]       mem_dest;
  logic [4:0]       wb_ctrl;
  logic [4:0]       wb_dest;
  logic             ex_valid;
  logic             mem_valid;
  logic             wb_valid;
  logic [CNT_W-1:0] bubble_count;

  modport master (
    output ctrl_id, rs_id, rt_id, rd_id, flush,
    input  hazard_stall, ex_ctrl, ex_dest, mem_ctrl, mem_dest, wb_ctrl, wb_dest,
           ex_valid, mem_valid, wb_valid, bubble_count
  );

  modport slave (
    input  ctrl_id, rs_id, rt_id, rd_id, flush,
    output hazard_stall, ex_ctrl, ex_dest, mem_ctrl, mem_dest, wb_ctrl, wb_dest,
           ex_valid, mem_valid, wb_valid, bubble_count
  );
endinterface

// File: rtl/ctrl_pipeline_stages_stage_reg.sv
// One pipeline register: synchronous reset plus a synchronous clear that
// loads a bubble (all zeros) instead of the incoming data.
module ctrl_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  always_comb begin
    data_d = clear ? '0 : din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign dout = data_q;
endmodule

// File: rtl/ctrl_pipeline_stages.sv
// ID/EX, EX/MEM and MEM/WB control registers with destination resolve,
// load-use hazard detection and a saturating bubble counter.
module ctrl_pipeline_stages #(
  parameter int CW_W  = ctrl_pkg::CW_W,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  ctrl_pipeline_stages_if.slave bus
);
  import ctrl_pkg::*;

  // Each stage keeps only the bits consumed at or after it; every register
  // packs {control slice, dest[4:0], valid} with the slice starting at bit 6.
  localparam int SLICE_W  = F_S0S2_HI + 1;
  localparam int IDEX_W   = SLICE_W + 6;
  localparam int EXMEM_W  = B_DM_RW + 1 + 6;
  localparam int MEMWB_W  = B_HIEN + 1 + 6;

  logic [CW_W-1:0]    ctrl_in;
  logic [SLICE_W-1:0] slice_id;
  logic [4:0]         dest_id;
  logic [4:0]         ex_dest;
  logic               hazard;
  logic               stall;
  logic               idex_clear;
  logic [IDEX_W-1:0]  idex_din;
  logic [IDEX_W-1:0]  idex_q;
  logic [EXMEM_W-1:0] exmem_din;
  logic [EXMEM_W-1:0] exmem_q;
  logic [MEMWB_W-1:0] memwb_din;
  logic [MEMWB_W-1:0] memwb_q;
  logic [CNT_W-1:0]   bubble_count_d;
  logic [CNT_W-1:0]   bubble_count_q;

  assign ctrl_in = bus.ctrl_id;
  assign ex_dest = idex_q[5:1];

  always_comb begin
    dest_id  = resolve_dest(ctrl_in[F_WD_HI:F_WD_LO], bus.rt_id, bus.rd_id);
    slice_id = ctrl_in[SLICE_W-1:0];
    // Writes to r0 (or no destination at all) must never reach the register file.
    if (dest_id == 5'd0) begin
      slice_id[B_RFEN] = 1'b0;
    end

    hazard = idex_q[6+B_LOAD] && idex_q[6+B_RFEN] && (ex_dest != 5'd0) &&
             ((ex_dest == bus.rs_id) || (ex_dest == bus.rt_id));
    stall      = hazard && !bus.flush;
    idex_clear = bus.flush || stall;
    idex_din   = {slice_id, dest_id, (ctrl_in != '0)};
    exmem_din  = {idex_q[6 +: B_DM_RW+1], idex_q[5:0]};
    memwb_din  = {exmem_q[6 +: B_HIEN+1], exmem_q[5:0]};

    bubble_count_d = bubble_count_q;
    if (stall && (bubble_count_q != '1)) begin
      bubble_count_d = bubble_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  ctrl_stage_reg #(.W(IDEX_W)) u_idex (
    .clk(clk), .reset(reset), .clear(idex_clear), .din(idex_din), .dout(idex_q)
  );

  ctrl_stage_reg #(.W(EXMEM_W)) u_exmem (
    .clk(clk), .reset(reset), .clear(1'b0), .din(exmem_din), .dout(exmem_q)
  );

  ctrl_stage_reg #(.W(MEMWB_W)) u_memwb (
    .clk(clk), .reset(reset), .clear(1'b0), .din(memwb_din), .dout(memwb_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_count_q <= '0;
    end else begin
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bus.hazard_stall = stall;
  assign bus.ex_ctrl      = {2'b00, idex_q[6+F_ALUOP_LO +: 5]};
  assign bus.ex_dest      = ex_dest;
  assign bus.ex_valid     = idex_q[0];
  assign bus.mem_ctrl     = exmem_q[6+B_MEM_MUX +: 6];
  assign bus.mem_dest     = exmem_q[5:1];
  assign bus.mem_valid    = exmem_q[0];
  assign bus.wb_ctrl      = memwb_q[6 +: 5];
  assign bus.wb_dest      = memwb_q[5:1];
  assign bus.wb_valid     = memwb_q[0];
  assign bus.bubble_count = bubble_count_q;
endmodule
